// File: rtl/cmdproc_parser_if.sv
// Purpose: bundles the command byte stream, the command issue handshake and
//          the read-response stream of cmdproc_parser.
// Ports (signals):
//   s_cmd_tdata/tvalid/tlast -> parser, s_cmd_tready <- parser   command bytes
//   cmd_addr_o/data_o/wr_o/valid_o <- parser, cmd_ack_i/rdata_i -> parser
//   m_resp_tdata/tvalid/tlast <- parser, m_resp_tready -> parser  response bytes
// Modports: slave = parser side, master = host/environment side.
interface cmdproc_parser_if #(
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned DATA_BYTES = 4
);
  logic [7:0]              s_cmd_tdata;
  logic                    s_cmd_tvalid;
  logic                    s_cmd_tready;
  logic                    s_cmd_tlast;
  logic [8*ADDR_BYTES-2:0] cmd_addr_o;
  logic [8*DATA_BYTES-1:0] cmd_data_o;
  logic                    cmd_wr_o;
  logic                    cmd_valid_o;
  logic                    cmd_ack_i;
  logic [8*DATA_BYTES-1:0] cmd_rdata_i;
  logic [7:0]              m_resp_tdata;
  logic                    m_resp_tvalid;
  logic                    m_resp_tready;
  logic                    m_resp_tlast;

  modport slave (
    input  s_cmd_tdata, s_cmd_tvalid, s_cmd_tlast, cmd_ack_i, cmd_rdata_i, m_resp_tready,
    output s_cmd_tready, cmd_addr_o, cmd_data_o, cmd_wr_o, cmd_valid_o,
           m_resp_tdata, m_resp_tvalid, m_resp_tlast
  );

  modport master (
    output s_cmd_tdata, s_cmd_tvalid, s_cmd_tlast, cmd_ack_i, cmd_rdata_i, m_resp_tready,
    input  s_cmd_tready, cmd_addr_o, cmd_data_o, cmd_wr_o, cmd_valid_o,
           m_resp_tdata, m_resp_tvalid, m_resp_tlast
  );
endinterface

// File: rtl/cmdproc_parser.sv
// Purpose: parses framed command bytes (address with read flag, optional write
//          data), issues the command, and streams back read data.
// Ports:
//   aclk           clock
//   cmdproc_reset  synchronous active-high reset
//   bus            cmdproc_parser_if.slave (command stream, issue, response)
//   err_o          high while halted after a framing error
//   err_count_o    saturating framing-error count
module cmdproc_parser #(
  parameter int unsigned ADDR_BYTES    = 3,
  parameter int unsigned DATA_BYTES    = 4,
  parameter int unsigned HALT_ON_ERROR = 1,
  parameter int unsigned TIMEOUT       = 0
) (
  input  logic            aclk,
  input  logic            cmdproc_reset,
  cmdproc_parser_if.slave bus,
  output logic            err_o,
  output logic [7:0]      err_count_o
);
  localparam int unsigned AW = 8*ADDR_BYTES - 1;
  localparam int unsigned DW = 8*DATA_BYTES;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = 16;
  localparam logic [CW-1:0] ADDR_LEN  = CW'(ADDR_BYTES);
  localparam logic [CW-1:0] WR_LEN    = CW'(ADDR_BYTES + DATA_BYTES);
  localparam logic [CW-1:0] RESP_LAST = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_ISSUE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;
  localparam logic [2:0] S_DISCARD = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] resp_q, resp_d;
  logic          wr_q, wr_d;
  logic          rlast_q, rlast_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          cvalid_q, rvalid_q, err_q;

  logic          s_rdy, byte_xfer, resp_xfer, last_byte, frame_err;
  logic [CW-1:0] cnt_inc;
  logic [TW-1:0] tmo_inc;

  // Ready is a pure decode of the state, forced low while reset is asserted.
  assign s_rdy = ~cmdproc_reset &
                 ((state_q == S_IDLE) || (state_q == S_ADDR) ||
                  (state_q == S_DATA) || (state_q == S_DISCARD));
  assign byte_xfer = bus.s_cmd_tvalid & s_rdy;
  assign resp_xfer = rvalid_q & bus.m_resp_tready;
  assign cnt_inc   = cnt_q + CW'(1);
  assign tmo_inc   = tmo_q + TW'(1);

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    addr_d    = addr_q;
    data_d    = data_q;
    resp_d    = resp_q;
    wr_d      = wr_q;
    rlast_d   = rlast_q;
    errcnt_d  = errcnt_q;
    last_byte = 1'b0;
    frame_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (byte_xfer) begin
          addr_d = AW'(bus.s_cmd_tdata[6:0]);
          wr_d   = ~bus.s_cmd_tdata[7];
          cnt_d  = CW'(1);
          // A single-byte frame can never be complete.
          if (bus.s_cmd_tlast) frame_err = 1'b1;
          else                 state_d   = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (byte_xfer) begin
          if (state_q == S_ADDR) addr_d = (addr_q << 8) | AW'(bus.s_cmd_tdata);
          else                   data_d = (data_q << 8) | DW'(bus.s_cmd_tdata);
          cnt_d     = cnt_inc;
          last_byte = wr_q ? (cnt_inc == WR_LEN) : (cnt_inc == ADDR_LEN);
          if (bus.s_cmd_tlast != last_byte)                 frame_err = 1'b1;
          else if (last_byte)                               state_d   = S_ISSUE;
          else if (state_q == S_ADDR && cnt_inc == ADDR_LEN) state_d  = S_DATA;
        end else begin
          // A byte in the limit cycle takes priority over the timeout.
          tmo_d = tmo_inc;
          if (TIMEOUT != 0 && tmo_inc == TMO_LIMIT) frame_err = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ack_i) begin
          if (wr_q) begin
            state_d = S_IDLE;
          end else begin
            resp_d  = bus.cmd_rdata_i;
            cnt_d   = '0;
            rlast_d = (DATA_BYTES == 1);
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_xfer) begin
          resp_d = resp_q << 8;
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_inc;
            rlast_d = (cnt_inc == RESP_LAST);
          end
        end
      end
      S_DISCARD: begin
        if (byte_xfer && bus.s_cmd_tlast) state_d = S_IDLE;
      end
      default: state_d = S_HALT;
    endcase

    // Framing errors: count, then halt or resynchronise.
    if (frame_err) begin
      tmo_d = '0;
      if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      if (HALT_ON_ERROR != 0)                  state_d = S_HALT;
      else if (byte_xfer && bus.s_cmd_tlast)   state_d = S_IDLE;
      else                                     state_d = S_DISCARD;
    end
  end

  always_ff @(posedge aclk) begin
    if (cmdproc_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      resp_q   <= '0;
      wr_q     <= 1'b0;
      rlast_q  <= 1'b0;
      errcnt_q <= '0;
      cvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      resp_q   <= resp_d;
      wr_q     <= wr_d;
      rlast_q  <= rlast_d;
      errcnt_q <= errcnt_d;
      cvalid_q <= (state_d == S_ISSUE);
      rvalid_q <= (state_d == S_RESP);
      err_q    <= (state_d == S_HALT);
    end
  end

  assign bus.s_cmd_tready  = s_rdy;
  assign bus.cmd_addr_o    = addr_q;
  assign bus.cmd_data_o    = data_q;
  assign bus.cmd_wr_o      = wr_q;
  assign bus.cmd_valid_o   = cvalid_q;
  assign bus.m_resp_tdata  = resp_q[DW-1 -: 8];
  assign bus.m_resp_tvalid = rvalid_q;
  assign bus.m_resp_tlast  = rlast_q;
  assign err_o             = err_q;
  assign err_count_o       = errcnt_q;
endmodule

// File: tb/tb_cmdproc_parser.sv
// Bench for cmdproc_parser: dut_a uses default parameters (halt on error),
// dut_b resynchronises on error and has a 16-cycle inter-byte timeout.
// sel chooses which instance sees the shared stimulus and is observed.
module tb_cmdproc_parser;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, ack = 1'b0, rready = 1'b0;
  logic [31:0] rdata = '0;
  int          total = 0, bad = 0, cv_cycles = 0;

  cmdproc_parser_if #(.ADDR_BYTES(3), .DATA_BYTES(4)) ifa ();
  cmdproc_parser_if #(.ADDR_BYTES(3), .DATA_BYTES(4)) ifb ();
  logic       erra, errb;
  logic [7:0] ecnta, ecntb;

  cmdproc_parser #(.ADDR_BYTES(3), .DATA_BYTES(4), .HALT_ON_ERROR(1), .TIMEOUT(0)) dut_a (
    .aclk(aclk), .cmdproc_reset(rst), .bus(ifa.slave), .err_o(erra), .err_count_o(ecnta));
  cmdproc_parser #(.ADDR_BYTES(3), .DATA_BYTES(4), .HALT_ON_ERROR(0), .TIMEOUT(16)) dut_b (
    .aclk(aclk), .cmdproc_reset(rst), .bus(ifb.slave), .err_o(errb), .err_count_o(ecntb));

  assign ifa.s_cmd_tdata   = tdata;
  assign ifa.s_cmd_tvalid  = tvalid & ~sel;
  assign ifa.s_cmd_tlast   = tlast;
  assign ifa.cmd_ack_i     = ack & ~sel;
  assign ifa.cmd_rdata_i   = rdata;
  assign ifa.m_resp_tready = rready & ~sel;
  assign ifb.s_cmd_tdata   = tdata;
  assign ifb.s_cmd_tvalid  = tvalid & sel;
  assign ifb.s_cmd_tlast   = tlast;
  assign ifb.cmd_ack_i     = ack & sel;
  assign ifb.cmd_rdata_i   = rdata;
  assign ifb.m_resp_tready = rready & sel;

  logic        s_rdy, cv, wr, rv, rl, err;
  logic [22:0] addr;
  logic [31:0] data;
  logic [7:0]  rd8, errcnt;
  assign s_rdy  = sel ? ifb.s_cmd_tready  : ifa.s_cmd_tready;
  assign cv     = sel ? ifb.cmd_valid_o   : ifa.cmd_valid_o;
  assign wr     = sel ? ifb.cmd_wr_o      : ifa.cmd_wr_o;
  assign addr   = sel ? ifb.cmd_addr_o    : ifa.cmd_addr_o;
  assign data   = sel ? ifb.cmd_data_o    : ifa.cmd_data_o;
  assign rv     = sel ? ifb.m_resp_tvalid : ifa.m_resp_tvalid;
  assign rl     = sel ? ifb.m_resp_tlast  : ifa.m_resp_tlast;
  assign rd8    = sel ? ifb.m_resp_tdata  : ifa.m_resp_tdata;
  assign err    = sel ? errb  : erra;
  assign errcnt = sel ? ecntb : ecnta;

  always @(posedge aclk) if (cv === 1'b1) cv_cycles <= cv_cycles + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge aclk); #1;
  endtask

  task automatic look();
    @(negedge aclk);
  endtask

  task automatic chk_reset_vals();
    chk("rst_tready", 64'(s_rdy), 64'(0));
    chk("rst_cmd_valid", 64'(cv), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_wr", 64'(wr), 64'(0));
    chk("rst_resp_valid", 64'(rv), 64'(0));
    chk("rst_resp_last", 64'(rl), 64'(0));
    chk("rst_resp_data", 64'(rd8), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_count", 64'(errcnt), 64'(0));
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; ack = 1'b0; rready = 1'b0;
    sync(); sync();
    look(); chk_reset_vals();
    sync(); rst = 1'b0;
    look(); chk("rdy_after_rst", 64'(s_rdy), 64'(1));
    sync();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    tdata = b; tlast = last; tvalid = 1'b1;
    look();
    while (s_rdy !== 1'b1 && n < 50) begin look(); n++; end
    chk("byte_accepted", 64'(s_rdy), 64'(1));
    sync();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic chk_cmd(input logic [22:0] a, input logic w, input logic [31:0] d);
    look();
    chk("cmd_valid_rise", 64'(cv), 64'(1));
    chk("cmd_addr", 64'(addr), 64'(a));
    chk("cmd_wr", 64'(wr), 64'(w));
    if (w) chk("cmd_data", 64'(data), 64'(d));
    chk("cmd_tready_low", 64'(s_rdy), 64'(0));
    sync();
  endtask

  task automatic ack_cmd(input logic [31:0] r, input int dly);
    for (int i = 0; i < dly; i++) begin
      look(); chk("cmd_valid_held", 64'(cv), 64'(1)); sync();
    end
    ack = 1'b1; rdata = r;
    sync();
    ack = 1'b0;
    look(); chk("cmd_valid_fall", 64'(cv), 64'(0));
    sync();
  endtask

  // Expected bytes come from r, most significant byte first.
  task automatic recv_resp(input logic [31:0] r, input bit rnd);
    int got, cyc;
    bit hold;
    logic [7:0] hd;
    logic hl;
    got = 0; cyc = 0; hold = 0; hd = '0; hl = 1'b0;
    while (got < 4 && cyc < 200) begin
      rready = rnd ? 1'($urandom % 2) : 1'b1;
      look();
      if (hold) begin
        chk("resp_hold_valid", 64'(rv), 64'(1));
        chk("resp_hold_data", 64'(rd8), 64'(hd));
        chk("resp_hold_last", 64'(rl), 64'(hl));
      end
      hold = 0;
      if (rv === 1'b1) begin
        if (rready) begin
          chk("resp_byte", 64'(rd8), 64'(8'(r >> (8*(3-got)))));
          chk("resp_last", 64'(rl), 64'(got == 3));
          got++;
        end else begin
          hold = 1; hd = rd8; hl = rl;
        end
      end
      sync();
      cyc++;
    end
    rready = 1'b0;
    chk("resp_count", 64'(got), 64'(4));
    look();
    chk("resp_done_valid", 64'(rv), 64'(0));
    chk("resp_done_idle", 64'(s_rdy), 64'(1));
    sync();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int exp_err, cv0;

    // Reset values and a write frame on the halting instance.
    sel = 1'b0;
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 1);
    chk_cmd(23'h001234, 1'b1, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      look();
      chk("wr_hold_valid", 64'(cv), 64'(1));
      chk("wr_hold_data", 64'(data), 64'(32'hDEADBEEF));
      chk("wr_hold_tready", 64'(s_rdy), 64'(0));
      sync();
    end
    ack_cmd(32'h0, 0);
    look(); chk("wr_back_idle", 64'(s_rdy), 64'(1)); sync();

    // Read with randomly throttled response.
    send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'h10, 1);
    chk_cmd(23'h000010, 1'b0, 32'h0);
    ack_cmd(32'hCAFEF00D, 2);
    recv_resp(32'hCAFEF00D, 1);

    // Reset in the middle of a response.
    begin
      int got;
      got = 0;
      send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'h44, 1);
      chk_cmd(23'h000044, 1'b0, 32'h0);
      ack_cmd(32'h11223344, 0);
      rready = 1'b1;
      for (int c = 0; c < 20 && got < 2; c++) begin
        look();
        if (rv === 1'b1) got++;
        sync();
      end
      chk("rstresp_two_bytes", 64'(got), 64'(2));
      rready = 1'b0; rst = 1'b1;
      sync();
      look();
      chk("rstresp_valid_drop", 64'(rv), 64'(0));
      chk("rstresp_tready_in_rst", 64'(s_rdy), 64'(0));
      sync();
      rst = 1'b0; rready = 1'b1; got = 0;
      for (int c = 0; c < 10; c++) begin
        look();
        if (rv !== 1'b0 || cv !== 1'b0) got++;
        sync();
      end
      rready = 1'b0;
      chk("rstresp_no_more", 64'(got), 64'(0));
      look(); chk("rstresp_idle", 64'(s_rdy), 64'(1)); sync();
    end

    // Early tlast on the halting instance.
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAA, 1);
    look();
    chk("halt_err", 64'(err), 64'(1));
    chk("halt_count", 64'(errcnt), 64'(1));
    chk("halt_tready", 64'(s_rdy), 64'(0));
    sync();
    tdata = 8'h5A; tvalid = 1'b1; tlast = 1'b1;
    for (int i = 0; i < 20; i++) begin
      look();
      chk("halt_stuck_tready", 64'(s_rdy), 64'(0));
      chk("halt_stuck_err", 64'(err), 64'(1));
      sync();
    end
    do_reset();

    // Resynchronising instance: missing tlast then discard.
    sel = 1'b1;
    do_reset();
    cv0 = cv_cycles;
    send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 1);
    look();
    chk("resync_count", 64'(errcnt), 64'(1));
    chk("resync_no_cmd", 64'(cv_cycles - cv0), 64'(0));
    chk("resync_no_halt", 64'(err), 64'(0));
    sync();
    send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'h20, 1);
    chk_cmd(23'h000020, 1'b0, 32'h0);
    ack_cmd(32'hA5C3961E, 1);
    recv_resp(32'hA5C3961E, 1);

    // Timeout: 16 idle cycles fires, a byte after 15 idle cycles does not.
    send_byte(8'h00, 0);
    repeat (15) sync();
    look(); chk("tmo_not_yet", 64'(errcnt), 64'(1)); sync();
    look();
    chk("tmo_fired", 64'(errcnt), 64'(2));
    chk("tmo_discard_ready", 64'(s_rdy), 64'(1));
    sync();
    send_byte(8'h77, 1);
    send_byte(8'h00, 0);
    repeat (15) sync();
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 1);
    chk_cmd(23'h001234, 1'b1, 32'hDEADBEEF);
    ack_cmd(32'h0, 0);
    look(); chk("tmo_gap15_count", 64'(errcnt), 64'(2)); sync();

    // Random frames against a frame-level model.
    exp_err = 2;
    for (int f = 0; f < 40; f++) begin
      logic        rdf;
      logic [22:0] a;
      logic [31:0] d, r;
      logic [23:0] hdr;
      int          kind, len, pos, extra;
      rdf = 1'($urandom % 2);
      a = 23'($urandom);
      d = $urandom;
      r = $urandom;
      kind = int'($urandom % 4);
      hdr = {rdf, a};
      q.delete();
      for (int i = 0; i < 3; i++) q.push_back(8'(hdr >> (8*(2-i))));
      if (!rdf) for (int i = 0; i < 4; i++) q.push_back(8'(d >> (8*(3-i))));
      len = q.size();
      cv0 = cv_cycles;
      if (kind < 2) begin
        for (int i = 0; i < len; i++) begin
          repeat (int'($urandom % 4)) sync();
          send_byte(q[i], 1'(i == len-1));
        end
        chk_cmd(a, ~rdf, d);
        ack_cmd(r, int'($urandom % 4));
        if (rdf) recv_resp(r, 1);
      end else begin
        if (kind == 2) begin
          pos = int'($urandom % (len-1));
          for (int i = 0; i <= pos; i++) begin
            repeat (int'($urandom % 4)) sync();
            send_byte(q[i], 1'(i == pos));
          end
        end else begin
          extra = int'($urandom % 3);
          for (int i = 0; i < len; i++) send_byte(q[i], 1'b0);
          for (int i = 0; i < extra; i++) send_byte(8'($urandom), 1'b0);
          send_byte(8'($urandom), 1'b1);
        end
        exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        look();
        chk("rnd_err_count", 64'(errcnt), 64'(exp_err));
        chk("rnd_err_no_cmd", 64'(cv_cycles - cv0), 64'(0));
        chk("rnd_err_idle", 64'(s_rdy), 64'(1));
        sync();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
